// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared encodings and match helpers for the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [0:0] {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // $zero is hardwired, so it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
      return (src != REG_ZERO) && (src == dst);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       we_m,
                                          input logic [4:0] dst_m,
                                          input logic       we_w,
                                          input logic [4:0] dst_w);
      if (we_m && reg_match(src, dst_m)) begin
         return FWD_MEM;
      end
      if (we_w && reg_match(src, dst_w)) begin
         return FWD_WB;
      end
      return FWD_RF;
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
// Module      : md_sequencer
// Description : IDLE/BUSY sequencer and latency counter for the mult/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic md_start_e_i,
   input  logic md_is_div_e_i,
   output logic md_busy_o,
   output logic md_done_o
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= MD_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // The E cycle counts toward latency, so the load value is one less than the total.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         MD_IDLE: begin
            if (md_start_e_i) begin
               state_d = MD_BUSY;
               count_d = md_is_div_e_i ? DIV_LOAD : MULT_LOAD;
            end
         end
         MD_BUSY: begin
            if (count_q == CNT_ONE) begin
               state_d = MD_IDLE;
               count_d = '0;
            end else begin
               count_d = count_q - CNT_ONE;
            end
         end
         default: begin
            state_d = MD_IDLE;
            count_d = '0;
         end
      endcase
   end

   assign md_busy_o = (state_q == MD_BUSY);
   assign md_done_o = (state_q == MD_BUSY) && (count_q == CNT_ONE);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Forwarding selects, stall/flush control and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  RsD,
   input  logic [4:0]  RtD,
   input  logic [4:0]  RsE,
   input  logic [4:0]  RtE,
   input  logic [4:0]  WriteRegE,
   input  logic [4:0]  WriteRegM,
   input  logic [4:0]  WriteRegW,
   input  logic        RegWriteE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemtoRegE,
   input  logic        MemtoRegM,
   input  logic        BranchD,
   input  logic        MfHiLoD,
   input  logic        MDStartD,
   input  logic        MDStartE,
   input  logic        MDIsDivE,
   output logic        ForwardAD,
   output logic        ForwardBD,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushE,
   output logic        MDBusy,
   output logic        MDDone,
   output logic [31:0] StallCycles
);

   logic        w_lwstall;
   logic        w_brstall;
   logic        w_mdstall;
   logic        w_stall;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   md_sequencer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_sequencer (
      .clk_i         (clk),
      .rst_i         (reset),
      .md_start_e_i  (MDStartE),
      .md_is_div_e_i (MDIsDivE),
      .md_busy_o     (MDBusy),
      .md_done_o     (MDDone)
   );

   assign ForwardAD = RegWriteM && reg_match(RsD, WriteRegM);
   assign ForwardBD = RegWriteM && reg_match(RtD, WriteRegM);
   assign ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
   assign ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);

   assign w_lwstall = MemtoRegE && (reg_match(RsD, RtE) || reg_match(RtD, RtE));

   // A branch compares in D, so an operand still being produced in E, or loaded in M, must wait.
   assign w_brstall = BranchD &&
                      ((RegWriteE && (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE))) ||
                       (MemtoRegM && (reg_match(RsD, WriteRegM) || reg_match(RtD, WriteRegM))));

   assign w_mdstall = (MfHiLoD && (MDStartE || MDBusy)) || (MDStartD && MDBusy);
   assign w_stall   = w_lwstall || w_brstall || w_mdstall;

   assign StallF = w_stall;
   assign StallD = w_stall;
   assign FlushE = w_stall;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (w_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign StallCycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard controller for the five-stage pipeline: generates decode-stage branch-compare forwarding selects (ForwardAD/ForwardBD), execute-stage ALU operand forwarding selects, and the StallF/StallD/FlushE controls. It also sequences the multi-cycle multiply/divide unit with an internal busy counter, stalling HI/LO readers and back-to-back mult/div starts until the result is written. It sits beside the pipeline registers and drives the decode-stage forwarding muxes, the execute-stage operand muxes and the F/D/E register enables and flushes.

## Interface
- MULT_CYCLES, 4, total mult latency in cycles including the E cycle; legal range 2 or more
- DIV_CYCLES, 32, total div latency in cycles including the E cycle; legal range 2 or more
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- RsD, RtD  in  5 each  decode source registers
- RsE, RtE  in  5 each  execute source registers
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  write-enable per stage
- MemtoRegE, MemtoRegM  in  1 each  load in E / M
- BranchD  in  1  branch compare in D
- MfHiLoD  in  1  mfhi/mflo in D
- MDStartD  in  1  mult/div in D
- MDStartE, MDIsDivE  in  1 each  mult/div in E; 1 = div
- ForwardAD, ForwardBD  out  1 each  1 selects ALUOutM for the decode compare operand
- ForwardAE, ForwardBE  out  2 each  00 RF, 10 ALUOutM, 01 ResultW
- StallF, StallD, FlushE  out  1 each  pipeline control
- MDBusy  out  1  mult/div in progress
- MDDone  out  1  one-cycle pulse on the last busy cycle; HI/LO write strobe
- StallCycles  out  32  saturating count of stalled cycles

## Operation
- Register 0 never matches for forwarding or hazard detection.
- ForwardAD = RsD≠0 & RegWriteM & WriteRegM==RsD. ForwardBD is the same with RtD.
- ForwardAE = 10 if RsE≠0 & RegWriteM & WriteRegM==RsE.
  - Otherwise 01 if RsE≠0 & RegWriteW & WriteRegW==RsE.
  - Otherwise 00.
  - M takes priority over W. ForwardBE is the same with RtE.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
  - Matches against register 0 are ignored.
- mdstall = (MfHiLoD & (MDStartE | MDBusy)) | (MDStartD & MDBusy).
- stall = lwstall | brstall | mdstall; StallF = StallD = FlushE = stall.
- Mult/div state machine:
  - States: IDLE and BUSY; count register sized to clog2(max(MULT_CYCLES, DIV_CYCLES)).
  - IDLE→BUSY when MDStartE = 1. Load count = (MDIsDivE ? DIV_CYCLES : MULT_CYCLES) − 1.
  - In BUSY, count decrements each cycle. MDDone = BUSY & count==1.
  - BUSY→IDLE when count==1 after decrement.
  - MDBusy = (state==BUSY).
  - MDStartE while BUSY cannot occur, because mdstall prevents it. If it does occur, ignore it and leave the count unchanged.
- StallCycles increments every cycle stall = 1 and saturates at 0xFFFFFFFF.

## Timing
- All forwarding and stall outputs are combinational from the inputs and the current state, with zero latency.
- MDBusy, MDDone and StallCycles are derived from registered state.
- Mult started in E at cycle t with MULT_CYCLES = N:
  - MDBusy is high for cycles t+1 … t+N−1.
  - MDDone pulses at t+N−1.
  - MDBusy is low at t+N.
- A dependent mfhi is stalled in D from cycle t through t+N−1 and enters E at t+N+1.
- Reset, synchronous and taking priority over everything, including mid-operation:
  - state becomes IDLE, count 0, MDBusy 0, MDDone 0, StallCycles 0.
  - No MDDone is emitted for an aborted operation.
- With all inputs 0, every output is 0.
- Simultaneous lwstall, brstall and mdstall produce a single stall per cycle; StallCycles increments by 1.

## Structure
- Shared package hazard_pkg holds:
  - forwarding select encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the MD state encoding;
  - the register-zero constant.
- One sub-module, md_sequencer, holds the IDLE/BUSY state, the count, MDBusy and MDDone.
- The top level holds the forwarding logic, the stall logic and StallCycles.

## Test plan
- Forwarding priority: RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 → ForwardAE=10. Drop RegWriteM → 01. Set RsE=0 → 00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 and StallCycles increments. Change RsD to 9 (RtD≠8) → stall=0.
- Branch after ALU op: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 → stall=1. Next cycle with RegWriteM=1, WriteRegM=3 and no E match → stall=0 and ForwardAD=1.
- Div, DIV_CYCLES=32: MDStartE=1, MDIsDivE=1 at t; MfHiLoD held high → MDBusy high for t+1…t+31, MDDone only at t+31, stall high for t…t+31, stall low at t+32.
- Reset mid-mult at t+2 → MDBusy=0 next cycle, no MDDone, StallCycles=0. A new MDStartE afterwards runs the full MULT_CYCLES.
- StallCycles preloaded near 0xFFFFFFFF (force or a long stall) → holds at 0xFFFFFFFF while stall stays high.
